// File: rtl/utf_pkg.sv
// Shared constants and state encoding for the UART receive/transmit framing path.
// Width constants are common to both directions so framing stays symmetric.
package utf_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_PUSH    = 2'd2,
        S_ERR     = 2'd3
    } utf_state_e;

    localparam int POS_ARRAY   = 8;
    localparam int BYTE_IN     = 8;
    localparam int DATA_FIFO   = POS_ARRAY * BYTE_IN;
    localparam int MIN_BYTES   = 4;
    localparam int TIMEOUT_CYC = 1024;

endpackage

// File: rtl/utf_timeout.sv
// Inter-byte silence counter: counts enabled cycles since the last clear and
// flags the cycle on which the silence window is used up.
module utf_timeout
    import utf_pkg::*;
#(
    parameter int timeout_cyc = TIMEOUT_CYC
) (
    input  logic sys_clk,
    input  logic sys_rst_l,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int TW = $clog2(timeout_cyc);
    localparam logic [TW-1:0] LAST_CNT = TW'(timeout_cyc - 1);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst_l) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LAST_CNT);

endmodule

// File: rtl/log_utf.sv
// UART receive assembler: packs received bytes little-endian into one FIFO word,
// closing a frame after pos_array bytes or after a period of inter-byte silence.
module log_utf
    import utf_pkg::*;
#(
    parameter int pos_array   = POS_ARRAY,
    parameter int byte_in     = BYTE_IN,
    parameter int data_fifo   = pos_array * byte_in,
    parameter int min_bytes   = MIN_BYTES,
    parameter int timeout_cyc = TIMEOUT_CYC
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_l,
    input  logic [byte_in-1:0]   rx_data,
    input  logic                 rx_ready,
    input  logic                 fifo_full,
    output logic [data_fifo-1:0] D_fifo,
    output logic                 push,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(pos_array) + 1;
    localparam int IW = $clog2(pos_array);
    localparam logic [CW-1:0] LAST_C = CW'(pos_array - 1);
    localparam logic [CW-1:0] MIN_C  = CW'(min_bytes);

    utf_state_e    state_q;
    logic [CW-1:0] cont_q;
    logic          expired;
    logic          tmr_clear;
    logic          tmr_enable;
    logic          clr_asm;

    // The assembly register is wiped whenever the FSM returns to idle.
    assign clr_asm    = ((state_q == S_PUSH) && !fifo_full) || (state_q == S_ERR);
    assign tmr_enable = (state_q == S_COLLECT) && !rx_ready;
    assign tmr_clear  = (state_q != S_COLLECT) || rx_ready || expired;

    utf_timeout #(
        .timeout_cyc(timeout_cyc)
    ) u_timeout (
        .sys_clk  (sys_clk),
        .sys_rst_l(sys_rst_l),
        .clear_i  (tmr_clear),
        .enable_i (tmr_enable),
        .expired_o(expired)
    );

    generate
        for (genvar gi = 0; gi < pos_array; gi++) begin : g_byte
            logic [byte_in-1:0] byte_q;
            logic               we;

            assign we = rx_ready &&
                        (((state_q == S_IDLE) && (gi == 0)) ||
                         ((state_q == S_COLLECT) && (cont_q[IW-1:0] == IW'(gi))));

            always_ff @(posedge sys_clk) begin
                if (sys_rst_l || clr_asm) begin
                    byte_q <= '0;
                end else if (we) begin
                    byte_q <= rx_data;
                end
            end

            assign D_fifo[gi*byte_in +: byte_in] = byte_q;
        end
    endgenerate

    always_ff @(posedge sys_clk) begin
        if (sys_rst_l) begin
            state_q <= S_IDLE;
            cont_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rx_ready) begin
                        cont_q  <= CW'(1);
                        state_q <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    // A byte arriving on the expiry cycle takes priority over the timeout.
                    if (rx_ready) begin
                        cont_q <= cont_q + 1'b1;
                        if (cont_q == LAST_C) begin
                            state_q <= S_PUSH;
                        end
                    end else if (expired) begin
                        state_q <= (cont_q >= MIN_C) ? S_PUSH : S_ERR;
                    end
                end
                S_PUSH: begin
                    if (!fifo_full) begin
                        state_q <= S_IDLE;
                        cont_q  <= '0;
                    end
                end
                S_ERR: begin
                    state_q <= S_IDLE;
                    cont_q  <= '0;
                end
                default: begin
                    state_q <= S_IDLE;
                    cont_q  <= '0;
                end
            endcase
        end
    end

    assign push      = !sys_rst_l && (state_q == S_PUSH) && !fifo_full;
    assign overrun   = !sys_rst_l && (state_q == S_PUSH) && rx_ready;
    assign frame_err = !sys_rst_l && (state_q == S_ERR);
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_log_utf.sv
// Bench for log_utf: frame-level reference model feeds an expectation queue,
// a negedge monitor pops and compares every push, frame_err and overrun.
module tb_log_utf;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready = 1'b0;
    logic        fifo_full = 1'b0;
    logic [63:0] D_fifo;
    logic        push;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        bit          is_err;
        logic [63:0] data;
        int          cyc;
    } ev_t;

    ev_t exp_q[$];
    int  ov_q[$];

    log_utf #(
        .timeout_cyc(T)
    ) dut (
        .sys_clk  (clk),
        .sys_rst_l(rst),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .fifo_full(fifo_full),
        .D_fifo   (D_fifo),
        .push     (push),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every DUT event must match the head of the expectation queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (push || frame_err) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: push=%0b frame_err=%0b at cycle %0d, none expected",
                             push, frame_err, cyc);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    $display("event cycle=%0d push=%0b frame_err=%0b D_fifo=%h", cyc, push, frame_err, D_fifo);
                    chk("event_kind_err", 64'(frame_err), 64'(e.is_err));
                    chk("event_cycle", 64'(cyc), 64'(e.cyc));
                    chk("push_frame_err_exclusive", 64'(push && frame_err), 64'd0);
                    if (!e.is_err) chk("push_data", D_fifo, e.data);
                end
            end
            if (overrun) begin
                if (ov_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_overrun: overrun=1 at cycle %0d, none expected", cyc);
                end else begin
                    int oc;
                    oc = ov_q.pop_front();
                    $display("overrun cycle=%0d", cyc);
                    chk("overrun_cycle", 64'(cyc), 64'(oc));
                    chk("overrun_frame_err_exclusive", 64'(frame_err), 64'd0);
                end
            end
        end
    end

    // Drives one frame and queues its expected outcome from the framing rules:
    // a gap of fewer than T idle cycles keeps the frame open; 8 bytes push one
    // cycle later (after any fifo_full hold); shorter frames close T+1 cycles
    // after the last byte, as a push if >= 4 bytes, otherwise as a frame error.
    task automatic drive_frame(input int n, input int gap, input int bnd_idx,
                               input int hold, input int ov_at, input bit pat);
        logic [63:0] word;
        logic [7:0]  b;
        int          t_last;
        int          g;
        ev_t         e;
        word   = '0;
        t_last = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                if (gap >= 0) g = gap;
                else g = ($urandom_range(0, 9) == 0) ? T - 1 : int'($urandom_range(0, 4));
                if (i == bnd_idx) g = T - 1;
                repeat (g) tick();
            end
            b = pat ? 8'(17 * (i + 1)) : 8'($urandom_range(0, 255));
            word[8*i +: 8] = b;
            rx_data  = b;
            rx_ready = 1'b1;
            t_last   = cyc;
            tick();
            rx_ready = 1'b0;
        end
        if (n == 8) begin
            e.is_err = 1'b0;
            e.data   = word;
            e.cyc    = t_last + 1 + hold;
            exp_q.push_back(e);
            for (int j = 1; j <= hold + 1; j++) begin
                fifo_full = (j <= hold);
                if (j == ov_at) begin
                    rx_data  = 8'($urandom_range(0, 255));
                    rx_ready = 1'b1;
                    ov_q.push_back(cyc);
                end
                @(negedge clk);
                chk("d_fifo_stable_in_push", D_fifo, word);
                chk("busy_in_push", 64'(busy), 64'd1);
                tick();
                rx_ready  = 1'b0;
                fifo_full = 1'b0;
            end
        end else begin
            e.is_err = (n < 4);
            e.data   = word;
            e.cyc    = t_last + T + 1;
            exp_q.push_back(e);
            repeat (T + 1) tick();
        end
        @(negedge clk);
        chk("busy_after_frame", 64'(busy), 64'd0);
        chk("d_fifo_cleared", D_fifo, 64'd0);
        tick();
    endtask

    initial begin
        int n;
        int hold;
        int ov_at;

        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_d_fifo", D_fifo, 64'd0);
        chk("reset_push", 64'(push), 64'd0);
        chk("reset_frame_err", 64'(frame_err), 64'd0);
        chk("reset_overrun", 64'(overrun), 64'd0);
        tick();

        drive_frame(8, 2, -1, 0, 0, 1'b1);     // full word, 3 cycles apart
        drive_frame(4, 1, -1, 0, 0, 1'b1);     // short frame closed by silence
        drive_frame(2, 1, -1, 0, 0, 1'b1);     // too short: frame error
        drive_frame(4, 0, -1, 0, 0, 1'b1);     // next frame starts clean
        drive_frame(8, 1, -1, 5, 2, 1'b1);     // FIFO full hold with overrun
        drive_frame(8, 1, 3, 0, 0, 1'b1);      // byte on the expiry cycle wins
        drive_frame(8, 0, -1, 0, 1, 1'b0);     // byte on the push cycle dropped
        drive_frame(7, 1, -1, 0, 0, 1'b0);

        // Reset mid-frame after the 5th byte.
        for (int i = 0; i < 5; i++) begin
            rx_data  = 8'(8'hA0 + i);
            rx_ready = 1'b1;
            tick();
            rx_ready = 1'b0;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_d_fifo", D_fifo, 64'd0);
        chk("midreset_push", 64'(push), 64'd0);
        chk("midreset_frame_err", 64'(frame_err), 64'd0);
        repeat (T + 3) tick();
        drive_frame(8, 1, -1, 0, 0, 1'b1);

        for (int k = 0; k < 30; k++) begin
            n     = ($urandom_range(0, 2) == 0) ? 8 : int'($urandom_range(1, 8));
            hold  = (n == 8) ? int'($urandom_range(0, 3)) : 0;
            ov_at = (n == 8) ? int'($urandom_range(0, hold + 1)) : 0;
            drive_frame(n, -1, -1, hold, ov_at, 1'b0);
        end

        repeat (5) tick();
        chk("no_missing_events", 64'(exp_q.size()), 64'd0);
        chk("no_missing_overruns", 64'(ov_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
